student_audio_sample_scheduler: RTL and testbench

//  Frame-level sequencer between the IIS codec handler and a single shared FIR core.
//  On each new codec frame it captures the L/R sample pair and routes it per mode_i:
//   - filter/mono: time-multiplexes the FIR core, L then R, over a valid/ready handshake.
//   - bypass/mute: no FIR use.

---
 rtl/student_audio_sched_pkg.sv | 25 ++
 rtl/student_sched_timeout_timer.sv | 30 +++
 rtl/student_audio_sample_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_student_audio_sample_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/student_audio_sched_pkg.sv
// Shared types and defaults for the audio sample scheduler and its timeout timer.
// No logic here: types and parameter defaults only, so no latency or backpressure.
package student_audio_sched_pkg;

  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 400;
  localparam int OVR_CNT_W   = 8;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    FILTER = 2'b01,
    MUTE   = 2'b10,
    MONO   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_L,
    WAIT_L,
    ISSUE_R,
    WAIT_R,
    COMMIT
  } state_e;

endpackage

// File: rtl/student_sched_timeout_timer.sv
// Per-channel watchdog: counts while enabled and flags expiry at TIMEOUT_CYC-1.
// Expire is combinational from the count register; no backpressure, clear beats enable.
module student_sched_timeout_timer #(
  parameter int TIMEOUT_CYC = 400
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/student_audio_sample_scheduler.sv
// Frame sequencer: captures each codec L/R pair, time-shares one FIR core, commits DAC outputs.
// Bypass/mute update 2 cycles after the edge; FIR offer held until ready or channel timeout.
module student_audio_sample_scheduler
  import student_audio_sched_pkg::*;
#(
  parameter int DATA_W      = student_audio_sched_pkg::DATA_W,
  parameter int TIMEOUT_CYC = student_audio_sched_pkg::TIMEOUT_CYC,
  parameter int OVR_CNT_W   = student_audio_sched_pkg::OVR_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 smp_valid_i,
  input  logic [DATA_W-1:0]    smp_l_i,
  input  logic [DATA_W-1:0]    smp_r_i,
  input  logic [1:0]           mode_i,
  output logic                 fir_valid_o,
  input  logic                 fir_ready_i,
  output logic [DATA_W-1:0]    fir_data_o,
  output logic                 fir_ch_o,
  input  logic                 fir_res_valid_i,
  input  logic [DATA_W-1:0]    fir_res_i,
  output logic [DATA_W-1:0]    out_l_o,
  output logic [DATA_W-1:0]    out_r_o,
  output logic                 out_update_o,
  output logic                 busy_o,
  output logic                 timeout_err_o,
  output logic [OVR_CNT_W-1:0] overrun_cnt_o,
  input  logic                 clr_err_i
);

  state_e state_q, state_d;
  mode_e  mode_q;
  logic   prev_q, smp_edge, accept, overrun;
  logic [DATA_W-1:0] raw_l_q, raw_r_q, res_l_q, res_r_q, res_l_d, res_r_d;
  logic [DATA_W-1:0] out_l_q, out_r_q;
  logic   out_update_q, timeout_err_q;
  logic [OVR_CNT_W-1:0] overrun_cnt_q;
  logic   tmr_clr, tmr_en, tmr_exp, to_set, l_done, r_done;

  assign smp_edge = smp_valid_i & ~prev_q;
  assign accept   = smp_edge && (state_q == IDLE);
  assign overrun  = smp_edge && (state_q != IDLE);

  student_sched_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  // Expiry in ISSUE wins over a same-cycle ready: the offer is abandoned and raw data passes.
  always_comb begin
    state_d     = state_q;
    fir_valid_o = 1'b0;
    fir_data_o  = '0;
    fir_ch_o    = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    to_set      = 1'b0;
    l_done      = 1'b0;
    r_done      = 1'b0;
    res_l_d     = res_l_q;
    res_r_d     = res_r_q;
    unique case (state_q)
      IDLE: begin
        if (smp_edge) begin
          if ((mode_e'(mode_i) == BYPASS) || (mode_e'(mode_i) == MUTE)) begin
            state_d = COMMIT;
          end else begin
            state_d = ISSUE_L;
            tmr_clr = 1'b1;
          end
        end
      end
      ISSUE_L: begin
        fir_valid_o = 1'b1;
        fir_data_o  = raw_l_q;
        tmr_en      = 1'b1;
        if (tmr_exp) begin
          res_l_d = raw_l_q;
          to_set  = 1'b1;
          l_done  = 1'b1;
        end else if (fir_ready_i) begin
          state_d = WAIT_L;
        end
      end
      WAIT_L: begin
        tmr_en = 1'b1;
        if (fir_res_valid_i) begin
          res_l_d = fir_res_i;
          l_done  = 1'b1;
        end else if (tmr_exp) begin
          res_l_d = raw_l_q;
          to_set  = 1'b1;
          l_done  = 1'b1;
        end
      end
      ISSUE_R: begin
        fir_valid_o = 1'b1;
        fir_data_o  = raw_r_q;
        fir_ch_o    = 1'b1;
        tmr_en      = 1'b1;
        if (tmr_exp) begin
          res_r_d = raw_r_q;
          to_set  = 1'b1;
          r_done  = 1'b1;
        end else if (fir_ready_i) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        tmr_en = 1'b1;
        if (fir_res_valid_i) begin
          res_r_d = fir_res_i;
          r_done  = 1'b1;
        end else if (tmr_exp) begin
          res_r_d = raw_r_q;
          to_set  = 1'b1;
          r_done  = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (l_done) begin
      if (mode_q == MONO) begin
        state_d = COMMIT;
      end else begin
        state_d = ISSUE_R;
        tmr_clr = 1'b1;
      end
    end
    if (r_done) state_d = COMMIT;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mode_q        <= BYPASS;
      prev_q        <= 1'b0;
      raw_l_q       <= '0;
      raw_r_q       <= '0;
      res_l_q       <= '0;
      res_r_q       <= '0;
      out_l_q       <= '0;
      out_r_q       <= '0;
      out_update_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= smp_valid_i;
      res_l_q      <= res_l_d;
      res_r_q      <= res_r_d;
      out_update_q <= (state_q == COMMIT);
      if (accept) begin
        raw_l_q <= smp_l_i;
        raw_r_q <= smp_r_i;
        mode_q  <= mode_e'(mode_i);
      end
      if (state_q == COMMIT) begin
        unique case (mode_q)
          BYPASS: begin out_l_q <= raw_l_q; out_r_q <= raw_r_q; end
          FILTER: begin out_l_q <= res_l_q; out_r_q <= res_r_q; end
          MUTE:   begin out_l_q <= '0;      out_r_q <= '0;      end
          MONO:   begin out_l_q <= res_l_q; out_r_q <= res_l_q; end
          default: begin out_l_q <= '0;     out_r_q <= '0;      end
        endcase
      end
      if (to_set) timeout_err_q <= 1'b1;
      else if (clr_err_i) timeout_err_q <= 1'b0;
      // A drop in the clearing cycle restarts the count at one.
      if (clr_err_i) overrun_cnt_q <= overrun ? OVR_CNT_W'(1) : '0;
      else if (overrun && (overrun_cnt_q != '1)) overrun_cnt_q <= overrun_cnt_q + 1'b1;
    end
  end

  assign out_l_o       = out_l_q;
  assign out_r_o       = out_r_q;
  assign out_update_o  = out_update_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = timeout_err_q;
  assign overrun_cnt_o = overrun_cnt_q;

endmodule

// File: tb/tb_student_audio_sample_scheduler.sv
// Directed bench: vector table of single frames plus hand sequences for timeout, overrun and reset.
module tb_student_audio_sample_scheduler;
  import student_audio_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smp_valid;
  logic [15:0] smp_l, smp_r;
  logic [1:0]  mode;
  logic        fir_valid, fir_ready, fir_ch, fir_res_valid;
  logic [15:0] fir_data, fir_res;
  logic [15:0] out_l, out_r;
  logic        out_update, busy, timeout_err, clr_err;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  student_audio_sample_scheduler dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .smp_valid_i     (smp_valid),
    .smp_l_i         (smp_l),
    .smp_r_i         (smp_r),
    .mode_i          (mode),
    .fir_valid_o     (fir_valid),
    .fir_ready_i     (fir_ready),
    .fir_data_o      (fir_data),
    .fir_ch_o        (fir_ch),
    .fir_res_valid_i (fir_res_valid),
    .fir_res_i       (fir_res),
    .out_l_o         (out_l),
    .out_r_o         (out_r),
    .out_update_o    (out_update),
    .busy_o          (busy),
    .timeout_err_o   (timeout_err),
    .overrun_cnt_o   (overrun_cnt),
    .clr_err_i       (clr_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // FIR core model: result = sample + add, returned dly cycles after the handshake.
  int          dly = 5;
  logic [15:0] add = 16'h0001;
  int          pend = 0;
  logic [15:0] pend_dat;
  int          ch0_cnt = 0, ch1_cnt = 0;

  initial begin
    fir_res_valid = 1'b0;
    fir_res = '0;
    forever begin
      @(negedge clk);
      fir_res_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            fir_res_valid = 1'b1;
            fir_res = pend_dat;
          end
        end
        if (fir_valid && fir_ready) begin
          pend_dat = fir_data + add;
          pend = dly;
          if (fir_ch) ch1_cnt++;
          else ch0_cnt++;
        end
      end
    end
  end

  task automatic start_frame(input logic [1:0] m, input logic [15:0] l, input logic [15:0] r);
    smp_l = l; smp_r = r; mode = m; smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    mode = ~m;
    smp_l = ~l;
    smp_r = ~r;
  endtask

  task automatic wait_update(input string nm);
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (out_update) begin found = 1; break; end
      @(negedge clk);
    end
    chk(nm, found, 1);
  endtask

  task automatic stall_frame(input logic [15:0] l, input logic [15:0] r, input bit clr_at_exp,
                             output int nl, output int nr, output bit data_ok);
    bit found = 0;
    nl = 0; nr = 0; data_ok = 1;
    smp_l = l; smp_r = r; mode = FILTER; smp_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      smp_valid = 1'b0;
      clr_err = 1'b0;
      if (out_update) begin found = 1; break; end
      if (fir_valid && !fir_ch) begin
        nl++;
        if (fir_data !== l) data_ok = 0;
        if (nl == 400 && clr_at_exp) begin
          chk("err_before_expiry", timeout_err, 0);
          clr_err = 1'b1;
        end
      end else if (fir_valid && fir_ch) begin
        if (nr == 0 && clr_at_exp) chk("err_clr_vs_timeout", timeout_err, 1);
        nr++;
        if (fir_data !== r) data_ok = 0;
      end
    end
    chk("stall_update_seen", found, 1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] l, r, add, exp_l, exp_r;
    int          exp_c0, exp_c1;
  } vec_t;

  vec_t vt[6];

  initial begin
    int b0, b1, nl, nr;
    bit ok;

    vt[0] = '{BYPASS, 16'h1234, 16'hABCD, 16'h0001, 16'h1234, 16'hABCD, 0, 0};
    vt[1] = '{FILTER, 16'h1234, 16'hABCD, 16'h0001, 16'h1235, 16'hABCE, 1, 1};
    vt[2] = '{MONO,   16'h0100, 16'h5555, 16'h0100, 16'h0200, 16'h0200, 1, 0};
    vt[3] = '{MUTE,   16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 0, 0};
    vt[4] = '{FILTER, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000, 16'h8001, 1, 1};
    vt[5] = '{BYPASS, 16'h8000, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 0, 0};

    rst_n = 1'b0; smp_valid = 1'b0; smp_l = '0; smp_r = '0; mode = BYPASS;
    fir_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_l", out_l, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_update", out_update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fir_valid", fir_valid, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ovr", overrun_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass latency: update exactly two cycles after the edge is driven, one cycle wide.
    smp_l = 16'h1234; smp_r = 16'hABCD; mode = BYPASS; smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    chk("byp_upd_c1", out_update, 0);
    chk("byp_busy_c1", busy, 1);
    @(negedge clk);
    chk("byp_upd_c2", out_update, 1);
    chk("byp_l", out_l, 16'h1234);
    chk("byp_r", out_r, 16'hABCD);
    @(negedge clk);
    chk("byp_upd_c3", out_update, 0);
    chk("byp_busy_c3", busy, 0);

    for (int i = 0; i < 6; i++) begin
      b0 = ch0_cnt; b1 = ch1_cnt; add = vt[i].add;
      start_frame(vt[i].mode, vt[i].l, vt[i].r);
      wait_update($sformatf("v%0d_update", i));
      chk($sformatf("v%0d_out_l", i), out_l, vt[i].exp_l);
      chk($sformatf("v%0d_out_r", i), out_r, vt[i].exp_r);
      chk($sformatf("v%0d_err", i), timeout_err, 0);
      chk($sformatf("v%0d_ch0", i), ch0_cnt - b0, vt[i].exp_c0);
      chk($sformatf("v%0d_ch1", i), ch1_cnt - b1, vt[i].exp_c1);
      @(negedge clk);
    end
    add = 16'h0001;

    // One extra edge while in WAIT_L counts once; the frame still commits.
    smp_l = 16'h2000; smp_r = 16'h3000; mode = FILTER; smp_valid = 1'b1;
    @(negedge clk); smp_valid = 1'b0;
    @(negedge clk); smp_valid = 1'b1;
    @(negedge clk); smp_valid = 1'b0;
    wait_update("ovr1_update");
    chk("ovr1_cnt", overrun_cnt, 1);
    chk("ovr1_l", out_l, 16'h2001);
    chk("ovr1_r", out_r, 16'h3001);
    @(negedge clk);

    // Clear in the same cycle as a new drop leaves the count at one.
    smp_l = 16'h2100; smp_r = 16'h3100; mode = FILTER; smp_valid = 1'b1;
    @(negedge clk); smp_valid = 1'b0;
    @(negedge clk); smp_valid = 1'b1; clr_err = 1'b1;
    @(negedge clk); smp_valid = 1'b0; clr_err = 1'b0;
    wait_update("ovr2_update");
    chk("ovr_clr_same_cycle", overrun_cnt, 1);
    @(negedge clk);

    // Saturation: toggle the frame level throughout a slow filter frame.
    dly = 300;
    smp_l = 16'h4000; smp_r = 16'h5000; mode = FILTER; smp_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (out_update) break;
      smp_valid = ~smp_valid;
    end
    smp_valid = 1'b0;
    chk("ovr_sat_update", out_update, 1);
    chk("ovr_sat_cnt", overrun_cnt, 8'hFF);
    chk("ovr_sat_l", out_l, 16'h4001);
    chk("ovr_sat_r", out_r, 16'h5001);
    chk("ovr_sat_err", timeout_err, 0);
    dly = 5;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_ovr", overrun_cnt, 0);

    // Stalled core: each channel offered stably for 400 cycles, then raw passthrough.
    fir_ready = 1'b0;
    stall_frame(16'h1111, 16'h2222, 1'b0, nl, nr, ok);
    chk("stall_nl", nl, 400);
    chk("stall_nr", nr, 400);
    chk("stall_stable", ok, 1);
    chk("stall_err", timeout_err, 1);
    chk("stall_l", out_l, 16'h1111);
    chk("stall_r", out_r, 16'h2222);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err", timeout_err, 0);
    stall_frame(16'h3333, 16'h4444, 1'b1, nl, nr, ok);
    chk("stall2_l", out_l, 16'h3333);
    chk("stall2_r", out_r, 16'h4444);
    fir_ready = 1'b1;
    @(negedge clk);

    // Reset in WAIT_R abandons the frame; a level held high through reset is a new edge.
    b1 = ch1_cnt;
    smp_l = 16'h6000; smp_r = 16'h7000; mode = FILTER; smp_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      smp_valid = 1'b0;
      if (ch1_cnt != b1) break;
    end
    chk("rst_reached_issue_r", ch1_cnt - b1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    smp_l = 16'hAAAA; smp_r = 16'h5555; mode = BYPASS; smp_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fir_valid", fir_valid, 0);
    chk("mid_rst_out_l", out_l, 0);
    chk("mid_rst_out_r", out_r, 0);
    chk("mid_rst_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    wait_update("post_rst_update");
    chk("post_rst_l", out_l, 16'hAAAA);
    chk("post_rst_r", out_r, 16'h5555);
    chk("post_rst_ovr", overrun_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
